// File: rtl/result_drain_pkg.sv
// Shared definitions for the results-SRAM drain path: geometry and FSM state encoding.
// Also imported by the readout bench.
package result_drain_pkg;

  localparam int ADDRESSSIZE    = 10;
  localparam int PARTIAL_SUM_BW = 24;
  localparam int MATRIX_SIZE    = 16;
  localparam int LANE_W         = $clog2(MATRIX_SIZE);
  localparam int WORD_W         = PARTIAL_SUM_BW * MATRIX_SIZE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/result_drain_lane_serializer.sv
// Holds one SRAM word and walks it out one lane per advance, LSB lane first.
// Load resets the lane index to 0.
module lane_serializer #(
  parameter int LANE_BW = 24,
  parameter int LANES   = 16,
  parameter int LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic [LANE_BW*LANES-1:0] i_word,
  input  logic                     i_advance,
  output logic [LANE_BW-1:0]       o_data,
  output logic [LW-1:0]            o_lane,
  output logic                     o_lane_last
);

  logic [LANE_BW*LANES-1:0] r_word;
  logic [LW-1:0]            r_lane;
  logic                     w_lane_last;

  assign w_lane_last = (r_lane == LW'(LANES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_lane <= '0;
    end else if (i_advance) begin
      r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
    end
  end

  assign o_data      = r_word[r_lane*LANE_BW +: LANE_BW];
  assign o_lane      = r_lane;
  assign o_lane_last = w_lane_last;

endmodule

// File: rtl/result_drain.sv
// Drains a contiguous block of results-SRAM words as a lane-per-beat valid/ready stream.
// One read per word, no prefetch: MATRIX_SIZE+2 cycles per word at full ready.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ADDRESSSIZE    = result_drain_pkg::ADDRESSSIZE,
  parameter int PARTIAL_SUM_BW = result_drain_pkg::PARTIAL_SUM_BW,
  parameter int MATRIX_SIZE    = result_drain_pkg::MATRIX_SIZE,
  parameter int LW             = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDRESSSIZE-1:0]              base_addr,
  input  logic [ADDRESSSIZE:0]                num_words,
  output logic                                sram_rd_en,
  output logic [ADDRESSSIZE-1:0]              sram_rd_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rd_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PARTIAL_SUM_BW-1:0]           out_data,
  output logic [LW-1:0]                       out_lane,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done
);

  state_t                    r_state;
  state_t                    w_next;
  logic [ADDRESSSIZE-1:0]    r_addr;
  logic [ADDRESSSIZE:0]      r_words;
  logic                      w_load;
  logic                      w_beat;
  logic                      w_lane_last;
  logic                      w_final_word;
  logic [PARTIAL_SUM_BW-1:0] w_data;
  logic [LW-1:0]             w_lane;

  assign w_final_word = (r_words == (ADDRESSSIZE+1)'(1));

  lane_serializer #(
    .LANE_BW (PARTIAL_SUM_BW),
    .LANES   (MATRIX_SIZE),
    .LW      (LW)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_word      (sram_rd_data),
    .i_advance   (w_beat),
    .o_data      (w_data),
    .o_lane      (w_lane),
    .o_lane_last (w_lane_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Address wraps naturally at 2^ADDRESSSIZE; word count is one bit wider so a full-depth drain fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_words <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_addr  <= base_addr;
      r_words <= num_words;
    end else if (w_beat && w_lane_last) begin
      r_addr  <= r_addr + 1'b1;
      r_words <= r_words - 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_beat       = 1'b0;
    sram_rd_en   = 1'b0;
    sram_rd_addr = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_lane     = '0;
    out_last     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = (num_words == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        sram_rd_en   = 1'b1;
        sram_rd_addr = r_addr;
        w_next       = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_load = 1'b1;
        w_next = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = w_data;
        out_lane  = w_lane;
        out_last  = w_lane_last && w_final_word;
        w_beat    = out_ready;
        if (out_ready && w_lane_last) begin
          w_next = w_final_word ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: behavioural SRAM, beat/read monitor, hand-derived expectations.
module tb_result_drain;
  import result_drain_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [9:0]            base_addr;
  logic [10:0]           num_words;
  logic                  sram_rd_en;
  logic [9:0]            sram_rd_addr;
  logic [383:0]          sram_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [23:0]           out_data;
  logic [3:0]            out_lane;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  logic [383:0] mem [0:1023];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           accept_cyc, first_vld_cyc, last_beat_cyc, done_cyc, done_cnt;
  logic [28:0]  beats [$];
  int           addr_q [$];
  logic         stall_prev;
  logic [23:0]  p_dat;
  logic [3:0]   p_lane;
  logic         p_last;

  result_drain dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_val(input int a, input int l);
    if (a == 5) return 24'(l + 1);
    return 24'((a << 8) | l);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (sram_rd_en) addr_q.push_back(int'(sram_rd_addr));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_prev) begin
        check("hold_vld", out_valid, 1);
        check("hold_dat", out_data, p_dat);
        check("hold_lane", out_lane, p_lane);
        check("hold_last", out_last, p_last);
      end
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_valid && out_ready) begin
        beats.push_back({out_last, out_lane, out_data});
        last_beat_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      p_dat  = out_data;
      p_lane = out_lane;
      p_last = out_last;
    end
  end

  task automatic clear_mon();
    beats.delete();
    addr_q.delete();
    done_cnt = 0;
    first_vld_cyc = -1;
    last_beat_cyc = -1;
    done_cyc = -1;
    stall_prev = 1'b0;
  endtask

  task automatic run_drain(input int base_a, input int n, input int mode, input bit busy_start);
    logic [3:0] pat;
    int limit;
    pat = 4'b1001;
    limit = n * 18 * 3 + 20;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'(base_a); num_words = 11'(n); out_ready = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    start = 1'b0; base_addr = '0; num_words = '0;
    for (int k = 0; k < limit && done_cnt == 0; k++) begin
      if (mode == 1) out_ready = pat[k % 4];
      if (busy_start && k == 4) begin
        start = 1'b1; base_addr = 10'd100; num_words = 11'd3;
      end
      @(posedge clk); #1;
      start = 1'b0; base_addr = '0; num_words = '0;
    end
    check("timeout", done_cnt > 0, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify(input int base_a, input int n);
    logic [28:0] b;
    int a;
    check("beat_cnt", beats.size(), n * 16);
    check("read_cnt", addr_q.size(), n);
    for (int i = 0; i < addr_q.size() && i < n; i++)
      check("rd_addr", addr_q[i], (base_a + i) % 1024);
    for (int i = 0; i < beats.size() && i < n * 16; i++) begin
      a = (base_a + i / 16) % 1024;
      b = beats[i];
      check("beat_dat", b[23:0], exp_val(a, i % 16));
      check("beat_lane", b[27:24], i % 16);
      check("beat_last", b[28], i == n * 16 - 1);
    end
    check("done_cnt", done_cnt, 1);
    check("busy_end", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b1;
    for (int a = 0; a < 1024; a++)
      for (int l = 0; l < 16; l++)
        mem[a][l*24 +: 24] = exp_val(a, l);
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", sram_rd_en, 0);
    check("rst_rd_addr", sram_rd_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_lane", out_lane, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // single word, first beat lands in the third cycle after the accepting edge
    run_drain(5, 1, 0, 1'b0);
    verify(5, 1);
    check("lat_first", first_vld_cyc - accept_cyc, 2);
    check("done_after_last", done_cyc - last_beat_cyc, 1);

    run_drain(5, 1, 1, 1'b0);
    verify(5, 1);

    run_drain(1022, 4, 0, 1'b0);
    verify(1022, 4);

    run_drain(3, 3, 1, 1'b0);
    verify(3, 3);

    run_drain(7, 0, 0, 1'b0);
    check("zero_reads", addr_q.size(), 0);
    check("zero_beats", beats.size(), 0);
    check("zero_vld", first_vld_cyc, -1);
    check("zero_done_cyc", done_cyc - accept_cyc, 0);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_busy", busy, 0);

    run_drain(0, 2, 0, 1'b1);
    verify(0, 2);

    // reset mid-drain at lane 7
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd0; num_words = 11'd2;
    @(posedge clk); #1;
    start = 1'b0; num_words = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid && out_lane == 4'd7) break;
    end
    check("rst_mid_lane", out_lane, 7);
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_lane", out_lane, 0);
    check("arst_last", out_last, 0);
    check("arst_busy", busy, 0);
    check("arst_rd_en", sram_rd_en, 0);
    repeat (2) @(posedge clk);
    #1;
    check("arst_done", done, 0);
    check("arst_no_done", done_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);
    run_drain(0, 1, 0, 1'b0);
    verify(0, 1);

    run_drain(0, 1024, 0, 1'b0);
    check("full_beats", beats.size(), 16384);
    check("full_reads", addr_q.size(), 1024);
    for (int i = 0; i < addr_q.size() && i < 1024; i++)
      if (addr_q[i] != i) check("full_addr", addr_q[i], i);
    check("full_done", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
